// File: rtl/ecg_buffer_ctrl_if.sv
// Stream and RAM-side signal bundle for the ECG sample buffer controller.
// master = controller side, slave = upstream/downstream/RAM environment side.
interface ecg_buffer_ctrl_if #(
  parameter int N_BITS = 64
);
  logic              in_valid;
  logic [N_BITS-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [N_BITS-1:0] out_data;
  logic              out_ready;
  logic              ram_rw;
  logic [N_BITS-1:0] ram_data_to_write;
  logic [19:0]       ram_address;
  logic [N_BITS-1:0] ram_data_out;

  modport master (
    input  in_valid, in_data, out_ready, ram_data_out,
    output in_ready, out_valid, out_data, ram_rw, ram_data_to_write, ram_address
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_data_out,
    input  in_ready, out_valid, out_data, ram_rw, ram_data_to_write, ram_address
  );
endinterface

// File: rtl/ecg_buffer_ctrl.sv
// Load/replay controller in front of a single-port sample RAM with a
// one-cycle registered read; the read path spends three cycles per word.
module ecg_buffer_ctrl #(
  parameter int SIZE_N = 8,
  parameter int N_BITS = 64,
  parameter int AW     = $clog2(SIZE_N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 start_read,
  output logic                 busy,
  output logic                 load_done,
  output logic                 read_done,
  ecg_buffer_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_OUT  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(SIZE_N - 1);

  state_t            state_reg;
  logic [AW-1:0]     ptr_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [N_BITS-1:0] out_data_reg;
  logic              busy_reg;
  logic              load_done_reg;
  logic              read_done_reg;
  logic              in_hs;
  logic              out_hs;

  assign in_hs  = bus.in_valid & in_ready_reg;
  assign out_hs = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      load_done_reg <= 1'b0;
      read_done_reg <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      read_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Load has priority when both start pulses coincide.
          if (start_load) begin
            state_reg    <= LOAD;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end else if (start_read) begin
            state_reg <= RD_ADDR;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          if (in_hs) begin
            if (ptr_reg == LAST_PTR) begin
              ptr_reg       <= '0;
              state_reg     <= IDLE;
              in_ready_reg  <= 1'b0;
              busy_reg      <= 1'b0;
              load_done_reg <= 1'b1;
            end else begin
              ptr_reg <= ptr_reg + AW'(1);
            end
          end
        end
        RD_ADDR: begin
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          // RAM output now reflects the address presented in RD_ADDR.
          out_data_reg  <= bus.ram_data_out;
          out_valid_reg <= 1'b1;
          state_reg     <= RD_OUT;
        end
        RD_OUT: begin
          if (out_hs) begin
            out_valid_reg <= 1'b0;
            if (ptr_reg == LAST_PTR) begin
              ptr_reg       <= '0;
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              read_done_reg <= 1'b1;
            end else begin
              ptr_reg   <= ptr_reg + AW'(1);
              state_reg <= RD_ADDR;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready          = in_ready_reg;
  assign bus.out_valid         = out_valid_reg;
  assign bus.out_data          = out_data_reg;
  assign bus.ram_rw            = in_hs;
  assign bus.ram_data_to_write = bus.in_data;
  assign bus.ram_address       = 20'(ptr_reg);
  assign busy                  = busy_reg;
  assign load_done             = load_done_reg;
  assign read_done             = read_done_reg;

endmodule

// File: tb/tb_ecg_buffer_ctrl.sv
// Directed bench for ecg_buffer_ctrl with a behavioural single-port RAM
// (sync write, registered read) hanging off the controller's RAM pins.
module tb_ecg_buffer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_load = 1'b0;
  logic start_read = 1'b0;
  logic busy, load_done, read_done;

  int vectors = 0;
  int errors  = 0;

  ecg_buffer_ctrl_if #(.N_BITS(64)) bus ();

  ecg_buffer_ctrl #(.SIZE_N(8), .N_BITS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_load (start_load),
    .start_read (start_read),
    .busy       (busy),
    .load_done  (load_done),
    .read_done  (read_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:7];
  always @(posedge clk) begin
    if (bus.ram_rw) mem[bus.ram_address[2:0]] <= bus.ram_data_to_write;
    bus.ram_data_out <= mem[bus.ram_address[2:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".busy"},      64'(busy),          64'd0);
    chk({tag, ".ram_rw"},    64'(bus.ram_rw),    64'd0);
    chk({tag, ".ram_addr"},  64'(bus.ram_address), 64'd0);
  endtask

  initial begin
    int word;
    int stalls;
    int budget;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // ---- reset state ----
    @(negedge clk); #1;
    chk_idle_outputs("rst");
    chk("rst.out_data",  bus.out_data, 64'd0);
    chk("rst.load_done", 64'(load_done), 64'd0);
    chk("rst.read_done", 64'(read_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- reset mid-LOAD after 3 handshakes ----
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'hA0 + 64'(i); #1;
      chk("rl.ram_addr", 64'(bus.ram_address), 64'(i));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1; chk("rl.pre_addr", 64'(bus.ram_address), 64'd3);
    #1; reset = 1'b1; #1;
    chk_idle_outputs("rl.async");
    @(negedge clk); reset = 1'b0;

    // ---- LOAD with in_valid toggling; starts again at address 0 ----
    @(negedge clk); start_load = 1'b1; #1;
    chk("tl.idle_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk); start_load = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (j % 2 == 0) begin
        bus.in_valid = 1'b1; bus.in_data = 64'h30 + 64'(j / 2); #1;
        chk("tl.wr_rw",   64'(bus.ram_rw), 64'd1);
        chk("tl.wr_addr", 64'(bus.ram_address), 64'(j / 2));
        chk("tl.wr_data", bus.ram_data_to_write, 64'h30 + 64'(j / 2));
      end else begin
        bus.in_valid = 1'b0; #1;
        chk("tl.stall_rw",   64'(bus.ram_rw), 64'd0);
        chk("tl.stall_addr", 64'(bus.ram_address), 64'((j + 1) / 2));
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; #1;
    chk("tl.load_done", 64'(load_done), 64'd1);
    chk("tl.busy", 64'(busy), 64'd0);

    // ---- full LOAD, in_valid always high, 0x10..0x17 ----
    @(negedge clk); #1;
    chk("fl.load_done_once", 64'(load_done), 64'd0);
    start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h10 + 64'(i); #1;
      chk("fl.rw",   64'(bus.ram_rw), 64'd1);
      chk("fl.addr", 64'(bus.ram_address), 64'(i));
      chk("fl.data", bus.ram_data_to_write, 64'h10 + 64'(i));
      chk("fl.done_early", 64'(load_done), 64'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; #1;
    chk("fl.load_done", 64'(load_done), 64'd1);
    chk("fl.in_ready",  64'(bus.in_ready), 64'd0);

    // ---- READ back-to-back with the done pulse, out_ready high ----
    start_read = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk); start_read = 1'b0;
    for (int w = 0; w < 8; w++) begin
      #1;
      chk("rd.addr_valid", 64'(bus.out_valid), 64'd0);
      chk("rd.addr",       64'(bus.ram_address), 64'(w));
      chk("rd.rw",         64'(bus.ram_rw), 64'd0);
      @(negedge clk); #1;
      chk("rd.wait_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk); #1;
      chk("rd.out_valid",  64'(bus.out_valid), 64'd1);
      chk("rd.out_data",   bus.out_data, 64'h10 + 64'(w));
      chk("rd.done_early", 64'(read_done), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("rd.read_done", 64'(read_done), 64'd1);
    chk("rd.busy",      64'(busy), 64'd0);
    chk("rd.valid_end", 64'(bus.out_valid), 64'd0);

    // ---- READ with 5-cycle backpressure on word 2 ----
    start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    word = 0; stalls = 0; budget = 200;
    while (word < 8 && budget > 0) begin
      #1;
      if (bus.out_valid) begin
        if (word == 2 && stalls < 5) begin
          bus.out_ready = 1'b0;
          stalls++;
          chk("bp.hold_data", bus.out_data, 64'h12);
          chk("bp.hold_addr", 64'(bus.ram_address), 64'd2);
        end else begin
          bus.out_ready = 1'b1;
          chk("bp.data", bus.out_data, 64'h10 + 64'(word));
          word++;
        end
      end
      @(negedge clk);
      budget--;
    end
    chk("bp.words", 64'(word), 64'd8);
    chk("bp.stalls", 64'(stalls), 64'd5);
    #1;
    chk("bp.read_done", 64'(read_done), 64'd1);
    @(negedge clk); #1;
    chk("bp.read_done_once", 64'(read_done), 64'd0);

    // ---- simultaneous starts: LOAD wins, start_read in LOAD ignored ----
    start_load = 1'b1; start_read = 1'b1;
    @(negedge clk); start_load = 1'b0; start_read = 1'b0; #1;
    chk("ss.in_ready",  64'(bus.in_ready), 64'd1);
    chk("ss.busy",      64'(busy), 64'd1);
    chk("ss.out_valid", 64'(bus.out_valid), 64'd0);
    start_read = 1'b1;
    @(negedge clk); start_read = 1'b0; #1;
    chk("ss.still_load", 64'(bus.in_ready), 64'd1);
    @(negedge clk); #1;
    chk("ss.no_read", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h40 + 64'(i); #1;
      chk("ss.addr", 64'(bus.ram_address), 64'(i));
      @(negedge clk);
    end
    bus.in_valid = 1'b0; #1;
    chk("ss.load_done", 64'(load_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ecg_buffer_ctrl.md
Name: ecg_buffer_ctrl

Overview:
- Controller that sits directly in front of the single-port sample RAM (sync write, 1-cycle registered read, shared address).
- LOAD phase: accepts a stream of SIZE_N ECG sample words over valid/ready and writes them to consecutive RAM addresses.
- READ phase: replays all SIZE_N words, in address order, to the downstream processing stage over valid/ready. Hides the RAM read latency and honours backpressure.

Parameters:
- SIZE_N, 8, number of words in the RAM (buffer depth); must be >= 2.
- N_BITS, 64, sample word width.
- AW, $clog2(SIZE_N), internal pointer width; zero-extended to 20 bits on ram_address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_load  in  1  pulse: begin LOAD phase (honoured only in IDLE).
- start_read  in  1  pulse: begin READ phase (honoured only in IDLE).
- in_valid  in  1  upstream sample valid.
- in_data  in  N_BITS  upstream sample.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  N_BITS  sample read back from RAM.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in any state except IDLE.
- load_done  out  1  one-cycle pulse after the last LOAD write.
- read_done  out  1  one-cycle pulse after the last READ handshake.
- ram_rw  out  1  RAM write enable.
- ram_data_to_write  out  N_BITS  RAM write data.
- ram_address  out  20  RAM address.
- ram_data_out  in  N_BITS  RAM registered read data.

Behaviour:
- Clocking and reset: one clock domain (clk); reset is asynchronous, active-high.
- Values while reset is asserted, and from any state when reset is asserted mid-operation:
  - state = IDLE, pointer = 0.
  - in_ready, out_valid, busy, load_done, read_done and ram_rw are all 0.
  - out_data = 0, ram_address = 0.
  - RAM contents are not cleared.
- State machine:
  - IDLE → LOAD when start_load.
  - IDLE → RD_ADDR when start_read.
  - If start_load and start_read are asserted in the same cycle, LOAD wins and start_read is dropped.
  - Start pulses outside IDLE are ignored.
- LOAD:
  - in_ready = 1 for the whole phase.
  - ram_address = pointer.
  - ram_data_to_write = in_data (combinational pass-through).
  - ram_rw = in_valid & in_ready (combinational), so the RAM writes on the handshake edge.
  - Each handshake increments the pointer.
  - On the handshake at pointer == SIZE_N-1: pointer wraps to 0, state → IDLE, load_done = 1 for the next cycle only.
  - Cycles with in_valid = 0 are stalls: no write, no pointer change.
- READ (ram_rw = 0 throughout):
  - RD_ADDR: ram_address = pointer. Always → RD_WAIT next cycle.
  - RD_WAIT: ram_data_out now holds data[pointer]. Register it into out_data; → RD_OUT.
  - RD_OUT: out_valid = 1. out_data and ram_address stay stable until the handshake (out_valid & out_ready).
  - On the handshake, if pointer < SIZE_N-1: increment pointer, → RD_ADDR.
  - On the handshake, if pointer == SIZE_N-1: pointer → 0, → IDLE, read_done = 1 for the next cycle only.
- Timing:
  - First out_valid occurs 3 cycles after the start_read cycle.
  - With out_ready held high, one word is delivered every 3 cycles.
  - Back-to-back phases: a start pulse in the same cycle as a done pulse is accepted.
- Widths: pointer is AW bits, zero-extended onto ram_address[19:0]. No other arithmetic.

Test Plan:
- Reset mid-LOAD: assert reset after 3 handshakes → all outputs 0 immediately (async), state IDLE. A new start_load then writes from address 0 again.
- Full load, SIZE_N=8, N_BITS=64, in_valid always 1, data 0x10..0x17 → ram_rw high 8 cycles on addresses 0..7 carrying 0x10..0x17. load_done pulses once, 1 cycle after the address-7 write.
- Load with in_valid toggling 1/0 → exactly 8 writes at addresses 0..7 in order; no write and no address advance in stall cycles.
- Read with out_ready=1 after the above load → out_data sequence 0x10..0x17. First out_valid 3 cycles after start_read, one word every 3 cycles. read_done pulses once after 0x17.
- Read with out_ready low for 5 cycles on word 2 → out_data holds 0x12 and ram_address holds 2 while stalled. Sequence completes with no loss or duplication.
- start_load and start_read in the same IDLE cycle → LOAD entered, in_ready=1, no out_valid. A start_read during LOAD has no effect.
